// File: rtl/seg_display_scheduler.sv
// Round-robin time-sharing of a 4-digit multiplexed seven-segment display.
// Each grant is held for a minimum number of full refresh frames.
module seg_display_scheduler #(
    parameter int TICK_DIV    = 100000,
    parameter int HOLD_FRAMES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [63:0] req_data,
    output logic [3:0]  grant,
    output logic [1:0]  active_id,
    output logic [3:0]  anode,
    output logic [3:0]  digit,
    output logic        scan_tick,
    output logic        frame_done,
    output logic        busy
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int FW = $clog2(HOLD_FRAMES + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_SHOW    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic [1:0]    state_r;
    logic [1:0]    next_state_s;
    logic [1:0]    rr_ptr_r;
    logic [TW-1:0] tick_r;
    logic [1:0]    idx_r;
    logic [1:0]    idx_nxt_s;
    logic [FW-1:0] frame_cnt_r;
    logic [FW-1:0] frame_nxt_s;
    logic [15:0]   latched_r;
    logic [1:0]    winner_s;
    logic          any_req_s;
    logic          other_req_s;
    logic          tick_wrap_s;
    logic          frame_end_s;
    logic          hold_met_s;
    logic          relatch_s;
    logic          load_s;
    logic [15:0]   winner_slice_s;
    logic [15:0]   active_slice_s;

    // Search starts at the pointer and wraps 3->0; first requester found wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
        logic [1:0] cand;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!found && r[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end else begin
                found = found;
            end
        end
    endfunction

    function automatic logic [15:0] slice16(input logic [63:0] d, input logic [1:0] id);
        case (id)
            2'd0:    slice16 = d[15:0];
            2'd1:    slice16 = d[31:16];
            2'd2:    slice16 = d[47:32];
            default: slice16 = d[63:48];
        endcase
    endfunction

    function automatic logic [3:0] nib(input logic [15:0] v, input logic [1:0] i);
        case (i)
            2'd0:    nib = v[3:0];
            2'd1:    nib = v[7:4];
            2'd2:    nib = v[11:8];
            default: nib = v[15:12];
        endcase
    endfunction

    // Arbitration, scan timing and next-state decisions
    always_comb begin
        winner_s       = rr_pick(req, rr_ptr_r);
        winner_slice_s = slice16(req_data, winner_s);
        active_slice_s = slice16(req_data, active_id);
        any_req_s      = |req;
        other_req_s    = |(req & ~(4'b0001 << active_id));
        tick_wrap_s    = (tick_r == TW'(TICK_DIV - 1));
        frame_end_s    = tick_wrap_s && (idx_r == 2'd3);
        if (tick_wrap_s) begin
            idx_nxt_s = idx_r + 2'd1;
        end else begin
            idx_nxt_s = idx_r;
        end
        if (frame_cnt_r >= FW'(HOLD_FRAMES)) begin
            frame_nxt_s = frame_cnt_r;
        end else begin
            frame_nxt_s = frame_cnt_r + FW'(1);
        end
        hold_met_s   = (frame_nxt_s >= FW'(HOLD_FRAMES));
        relatch_s    = 1'b0;
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                next_state_s = ST_SHOW;
            end
            ST_SHOW: begin
                // Request changes only matter once the hold has been served
                if (frame_end_s && hold_met_s) begin
                    if (other_req_s) begin
                        next_state_s = ST_RELEASE;
                    end else if (req[active_id]) begin
                        next_state_s = ST_SHOW;
                        relatch_s    = 1'b1;
                    end else begin
                        next_state_s = ST_RELEASE;
                    end
                end else begin
                    next_state_s = ST_SHOW;
                end
            end
            ST_RELEASE: begin
                if (any_req_s) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
        load_s = (next_state_s == ST_LOAD);
    end

    // State, counters and all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= 2'd0;
            tick_r      <= '0;
            idx_r       <= 2'd0;
            frame_cnt_r <= '0;
            latched_r   <= 16'h0000;
            grant       <= 4'b0000;
            active_id   <= 2'd0;
            anode       <= 4'b1111;
            digit       <= 4'h0;
            scan_tick   <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            busy       <= (next_state_s != ST_IDLE);
            scan_tick  <= 1'b0;
            frame_done <= 1'b0;
            if (load_s) begin
                grant       <= 4'b0001 << winner_s;
                active_id   <= winner_s;
                latched_r   <= winner_slice_s;
                tick_r      <= '0;
                idx_r       <= 2'd0;
                frame_cnt_r <= '0;
                rr_ptr_r    <= winner_s + 2'd1;
                anode       <= 4'b1111;
                digit       <= 4'h0;
            end else begin
                case (state_r)
                    ST_LOAD: begin
                        anode <= 4'b1110;
                        digit <= latched_r[3:0];
                    end
                    ST_SHOW: begin
                        if (tick_wrap_s) begin
                            tick_r    <= '0;
                            idx_r     <= idx_nxt_s;
                            scan_tick <= 1'b1;
                            if (frame_end_s) begin
                                frame_done  <= 1'b1;
                                frame_cnt_r <= frame_nxt_s;
                            end else begin
                                frame_cnt_r <= frame_cnt_r;
                            end
                        end else begin
                            tick_r <= tick_r + TW'(1);
                        end
                        if (next_state_s != ST_SHOW) begin
                            grant <= 4'b0000;
                            anode <= 4'b1111;
                            digit <= 4'h0;
                        end else if (relatch_s) begin
                            latched_r <= active_slice_s;
                            anode     <= 4'b1110;
                            digit     <= active_slice_s[3:0];
                        end else begin
                            anode <= ~(4'b0001 << idx_nxt_s);
                            digit <= nib(latched_r, idx_nxt_s);
                        end
                    end
                    default: begin
                        grant <= 4'b0000;
                        anode <= 4'b1111;
                        digit <= 4'h0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Scoreboard bench for seg_display_scheduler: expected lit digits are queued when
// stimulus is applied and compared each time the display moves to a new digit.
module tb_seg_display_scheduler;

    localparam int TICK_DIV    = 4;
    localparam int HOLD_FRAMES = 2;
    localparam int GRANT_LEN   = 1 + 4 * TICK_DIV * HOLD_FRAMES;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [63:0] req_data = 64'h0;
    logic [3:0]  grant;
    logic [1:0]  active_id;
    logic [3:0]  anode;
    logic [3:0]  digit;
    logic        scan_tick;
    logic        frame_done;
    logic        busy;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [11:0] sb_q[$];
    logic        mon_en = 1'b0;
    logic [3:0]  prev_anode = 4'b1111;
    int          held = 0;
    int          fd_cnt = 0;
    int          exp_rr = 0;

    always #5 clk = ~clk;

    seg_display_scheduler #(.TICK_DIV(TICK_DIV), .HOLD_FRAMES(HOLD_FRAMES)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .grant      (grant),
        .active_id  (active_id),
        .anode      (anode),
        .digit      (digit),
        .scan_tick  (scan_tick),
        .frame_done (frame_done),
        .busy       (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_frames(input int id, input logic [15:0] d, input int nframes);
        for (int f = 0; f < nframes; f++) begin
            for (int i = 0; i < 4; i++) begin
                sb_q.push_back({4'(1 << id), ~(4'b0001 << i), d[4*i +: 4]});
            end
        end
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy && c < 200) begin
            @(negedge clk);
            c++;
        end
        check_eq("idle_wait", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_rise(output int gap);
        gap = 0;
        while (grant == 4'b0000 && gap < 100) begin
            @(negedge clk);
            gap++;
        end
    endtask

    task automatic measure_run(output int len);
        len = 0;
        while (grant != 4'b0000 && len < 200) begin
            @(negedge clk);
            len++;
        end
    endtask

    // Single requester from idle: latency, data change effective from next re-latch, drop at end.
    task automatic run_single(input int id, input logic [15:0] d1, input logic [15:0] d2);
        int c;
        int fd_base;
        fd_base = fd_cnt;
        push_frames(id, d1, 3);
        push_frames(id, d2, 1);
        @(negedge clk);
        req_data[16*id +: 16] = d1;
        req = 4'b0001 << id;
        @(negedge clk);
        check_eq("lat_grant", {28'd0, grant}, {28'd0, 4'b0001 << id});
        check_eq("lat_id", {30'd0, active_id}, 32'(id));
        @(negedge clk);
        check_eq("lat_anode", {28'd0, anode}, 32'hE);
        c = 0;
        while (anode != 4'b1111 && c < 200) begin
            @(negedge clk);
            c++;
            if (c == 40) req_data[16*id +: 16] = d2;
            if (c == 56) req = 4'b0000;
        end
        check_eq("lit_run", 32'(c), 32'd64);
        @(negedge clk);
        #1;
        check_eq("frame_cnt", 32'(fd_cnt - fd_base), 32'd4);
        wait_idle();
        exp_rr = (id + 1) % 4;
    endtask

    // Scoreboard monitor: one compare per newly lit digit, plus dwell time per digit
    always @(negedge clk) begin
        if (anode != 4'b1111) begin
            if (anode != prev_anode) begin
                if (mon_en) begin
                    if (prev_anode != 4'b1111) check_eq("digit_hold", 32'(held), 32'(TICK_DIV));
                    check_eq("one_anode", 32'($countones(~anode)), 32'd1);
                    if (sb_q.size() == 0) check_eq("sb_depth", 32'(sb_q.size()), 32'd1);
                    else check_eq("sb_disp", {20'd0, grant, anode, digit}, {20'd0, sb_q.pop_front()});
                end
                held <= 1;
            end else begin
                held <= held + 1;
            end
        end else if (prev_anode != 4'b1111 && mon_en) begin
            check_eq("digit_hold", 32'(held), 32'(TICK_DIV));
        end
        if (frame_done) fd_cnt <= fd_cnt + 1;
        prev_anode <= anode;
    end

    initial begin
        int gap;
        int len;
        int id;
        logic [15:0] s;

        repeat (3) @(negedge clk);
        check_eq("rst_grant", {28'd0, grant}, 32'd0);
        check_eq("rst_id", {30'd0, active_id}, 32'd0);
        check_eq("rst_anode", {28'd0, anode}, 32'hF);
        check_eq("rst_digit", {28'd0, digit}, 32'd0);
        check_eq("rst_tick", {31'd0, scan_tick}, 32'd0);
        check_eq("rst_fdone", {31'd0, frame_done}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;

        // Asynchronous reset in the middle of SHOW, then pointer restarts at 0
        req_data[15:0] = 16'hABCD;
        req = 4'b0001;
        len = 0;
        while (anode == 4'b1111 && len < 20) begin
            @(negedge clk);
            len++;
        end
        repeat (10) @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_eq("arst_anode", {28'd0, anode}, 32'hF);
        check_eq("arst_grant", {28'd0, grant}, 32'd0);
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_digit", {28'd0, digit}, 32'd0);
        req = 4'b0011;
        req_data[15:0] = 16'h9876;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rr_restart", {28'd0, grant}, 32'h1);
        check_eq("rr_id", {30'd0, active_id}, 32'd0);
        @(negedge clk);
        check_eq("first_anode", {28'd0, anode}, 32'hE);
        check_eq("first_digit", {28'd0, digit}, 32'h6);
        req = 4'b0000;
        wait_idle();
        exp_rr = 1;
        mon_en = 1'b1;

        // Requester 0 held; 5678 shows only after the next re-latch
        run_single(0, 16'h1234, 16'h5678);

        // One-cycle pulse on req[2] still earns a full hold
        req_data[47:32] = 16'hBEEF;
        push_frames(2, 16'hBEEF, HOLD_FRAMES);
        @(negedge clk);
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        check_eq("pulse_grant", {28'd0, grant}, 32'h4);
        measure_run(len);
        check_eq("pulse_len", 32'(len), 32'(GRANT_LEN));
        check_eq("rel_anode", {28'd0, anode}, 32'hF);
        check_eq("rel_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check_eq("idle_busy", {31'd0, busy}, 32'd0);
        check_eq("idle_anode", {28'd0, anode}, 32'hF);
        exp_rr = 3;

        // Pointer at 3 with only req[0]: winner 0, frames back to back
        run_single(0, 16'hA5C3, 16'h0F1E);

        // All four requesting: strict rotation from the pointer
        req_data = 64'hCDEF_89AB_4567_0123;
        for (int k = 0; k < 5; k++) begin
            id = (exp_rr + k) % 4;
            s = req_data[16*id +: 16];
            push_frames(id, s, HOLD_FRAMES);
        end
        @(negedge clk);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_rise(gap);
            if (k > 0) check_eq("rr_gap", 32'(gap), 32'd1);
            check_eq("rr_grant", {28'd0, grant}, {28'd0, 4'b0001 << ((exp_rr + k) % 4)});
            if (k == 4) req = 4'b0000;
            measure_run(len);
            check_eq("rr_len", 32'(len), 32'(GRANT_LEN));
        end
        wait_idle();
        exp_rr = (exp_rr + 5) % 4;

        // req[3] arriving mid-hold waits for the hold to expire
        s = req_data[31:16];
        push_frames(1, s, HOLD_FRAMES);
        s = req_data[63:48];
        push_frames(3, s, HOLD_FRAMES);
        @(negedge clk);
        req = 4'b0010;
        wait_rise(gap);
        check_eq("late_g1", {28'd0, grant}, 32'h2);
        len = 0;
        while (grant != 4'b0000 && len < 200) begin
            @(negedge clk);
            len++;
            if (len == 6) req = 4'b1010;
            if (len == 9) req = 4'b1000;
        end
        check_eq("late_len1", 32'(len), 32'(GRANT_LEN));
        wait_rise(gap);
        check_eq("late_gap", 32'(gap), 32'd1);
        check_eq("late_g3", {28'd0, grant}, 32'h8);
        len = 0;
        while (grant != 4'b0000 && len < 200) begin
            @(negedge clk);
            len++;
            if (len == 3) req = 4'b0000;
        end
        check_eq("late_len3", 32'(len), 32'(GRANT_LEN));
        wait_idle();

        repeat (5) @(negedge clk);
        check_eq("sb_left", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
